// File: rtl/sap_pkg.sv
// Shared SAP definitions: opcode constants, opcode width and the T-state ring encoding.
package sap_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_LDA = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPC_W-1:0] OP_STA = 4'h3;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h4;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h5;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'h6;
  localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
  localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  // The encoding doubles as the debug t_state value (T1 reads as 0).
  typedef enum logic [2:0] {
    T1 = 3'd0,
    T2 = 3'd1,
    T3 = 3'd2,
    T4 = 3'd3,
    T5 = 3'd4,
    T6 = 3'd5
  } t_state_t;

  function automatic t_state_t next_t(input t_state_t t);
    case (t)
      T1:      return T2;
      T2:      return T3;
      T3:      return T4;
      T4:      return T5;
      T5:      return T6;
      default: return T1;
    endcase
  endfunction

endpackage

// File: rtl/sap_ram.sv
// SAP program/data RAM: combinational read, synchronous write, with the write
// port shared between the programmer (program mode) and the core's STA.
module sap_ram
  import sap_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              prog_sel,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_data,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    we    = prog_sel ? prog_we   : core_we;
    waddr = prog_sel ? prog_addr : core_addr;
    wdata = prog_sel ? prog_data : core_data;
  end

  // Contents deliberately survive reset so a loaded program can be rerun.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sap_core.sv
// SAP-1 style core: six-state ring sequencer, A/B registers, output register.
// Define SAP_CORE_JUMP_EN to build the JMP/JZ/JC opcodes and the Z/C flags.
module sap_core
  import sap_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              CLR_bar,
  input  logic              run_or_prog,
  input  logic              prog_write,
  input  logic [ADDR_W-1:0] programmer_address,
  input  logic [DATA_W-1:0] programmer_data,
  output logic [DATA_W-1:0] display,
  output logic              display_valid,
  output logic              HLT_bar,
  output logic [2:0]        t_state
);

  t_state_t          state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] ram_rdata;
  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] operand_ext;
  logic              core_we;

`ifdef SAP_CORE_JUMP_EN
  logic              z_flag;
  logic              c_flag;
  // One extra bit holds carry-out for ADD and borrow for SUB.
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
`else
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  assign sum  = a + b;
  assign diff = a - b;
`endif

  assign opcode      = ir[ADDR_W+OPC_W-1:ADDR_W];
  assign operand     = ir[ADDR_W-1:0];
  assign operand_ext = {{(DATA_W-ADDR_W){1'b0}}, operand};
  assign t_state     = state;
  assign core_we     = run_or_prog && HLT_bar && (state == T5) && (opcode == OP_STA);

  sap_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk      (CLK),
    .prog_sel (!run_or_prog),
    .prog_we  (prog_write),
    .prog_addr(programmer_address),
    .prog_data(programmer_data),
    .core_we  (core_we),
    .core_addr(mar),
    .core_data(a),
    .raddr    (mar),
    .rdata    (ram_rdata)
  );

  // Program mode restarts the fetch at address 0 but keeps the datapath
  // registers; HALT freezes everything including the T-state.
  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      state         <= T1;
      pc            <= '0;
      mar           <= '0;
      ir            <= '0;
      a             <= '0;
      b             <= '0;
      display       <= '0;
      display_valid <= 1'b0;
      HLT_bar       <= 1'b1;
`ifdef SAP_CORE_JUMP_EN
      z_flag        <= 1'b0;
      c_flag        <= 1'b0;
`endif
    end else if (!run_or_prog) begin
      state         <= T1;
      pc            <= '0;
      HLT_bar       <= 1'b1;
      display_valid <= 1'b0;
    end else if (!HLT_bar) begin
      display_valid <= 1'b0;
    end else begin
      display_valid <= 1'b0;
      state         <= next_t(state);
      case (state)
        T1: mar <= pc;
        T2: pc  <= pc + 1'b1;
        T3: ir  <= ram_rdata;
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: mar <= operand;
            OP_LDI: begin
              a <= operand_ext;
`ifdef SAP_CORE_JUMP_EN
              z_flag <= (operand_ext == '0);
`endif
            end
`ifdef SAP_CORE_JUMP_EN
            OP_JMP: pc <= operand;
            OP_JZ:  if (z_flag) pc <= operand;
            OP_JC:  if (c_flag) pc <= operand;
`endif
            OP_OUT: begin
              display       <= a;
              display_valid <= 1'b1;
            end
            OP_HLT: begin
              HLT_bar <= 1'b0;
              state   <= T4;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              a <= ram_rdata;
`ifdef SAP_CORE_JUMP_EN
              z_flag <= (ram_rdata == '0);
`endif
            end
            OP_ADD, OP_SUB: b <= ram_rdata;
            default: ;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD: begin
              a <= sum[DATA_W-1:0];
`ifdef SAP_CORE_JUMP_EN
              c_flag <= sum[DATA_W];
              z_flag <= (sum[DATA_W-1:0] == '0);
`endif
            end
            OP_SUB: begin
              a <= diff[DATA_W-1:0];
`ifdef SAP_CORE_JUMP_EN
              c_flag <= !diff[DATA_W];
              z_flag <= (diff[DATA_W-1:0] == '0);
`endif
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_core.sv
// Scoreboard bench for sap_core: an instruction-level model predicts OUT values
// and halt timing; a monitor compares every display_valid pulse.
module tb_sap_core;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
`ifdef SAP_CORE_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              CLR_bar;
  logic              run_or_prog;
  logic              prog_write;
  logic [ADDR_W-1:0] programmer_address;
  logic [DATA_W-1:0] programmer_data;
  logic [DATA_W-1:0] display;
  logic              display_valid;
  logic              HLT_bar;
  logic [2:0]        t_state;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_ram[DEPTH];
  logic [7:0] prog_img[DEPTH];
  int         m_a, m_b, m_disp;
  bit         m_z, m_c;

  sap_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK               (CLK),
    .CLR_bar           (CLR_bar),
    .run_or_prog       (run_or_prog),
    .prog_write        (prog_write),
    .programmer_address(programmer_address),
    .programmer_data   (programmer_data),
    .display           (display),
    .display_valid     (display_valid),
    .HLT_bar           (HLT_bar),
    .t_state           (t_state)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every OUT pulse must match the oldest predicted display value.
  always @(negedge CLK) begin
    if (display_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_pulse: got display 0x%0h, expected no pulse", display);
      end else begin
        check_output("display_pulse", display, exp_q.pop_front());
      end
    end
  end

  // Executes the program in m_ram one whole instruction at a time.
  task automatic run_model(input int max_instr, output int n_exec, output bit halted);
    int pc;
    int op;
    int opd;
    int s;
    logic [7:0] ir;
    pc     = 0;
    n_exec = 0;
    halted = 1'b0;
    for (int i = 0; i < max_instr; i++) begin
      ir  = m_ram[pc];
      pc  = (pc + 1) % DEPTH;
      op  = int'(ir[7:4]);
      opd = int'(ir[3:0]);
      if (op == 15) begin
        halted = 1'b1;
        break;
      end
      case (op)
        0: begin m_a = int'(m_ram[opd]); m_z = (m_a == 0); end
        1: begin
          m_b = int'(m_ram[opd]);
          s   = m_a + m_b;
          m_c = (s > 255);
          m_a = s % 256;
          m_z = (m_a == 0);
        end
        2: begin
          m_b = int'(m_ram[opd]);
          m_c = (m_a >= m_b);
          m_a = (m_a - m_b + 256) % 256;
          m_z = (m_a == 0);
        end
        3: m_ram[opd] = 8'(m_a);
        4: begin m_a = opd; m_z = (opd == 0); end
        5: if (JUMP_EN) pc = opd;
        6: if (JUMP_EN && m_z) pc = opd;
        7: if (JUMP_EN && m_c) pc = opd;
        14: begin m_disp = m_a; exp_q.push_back(8'(m_a)); end
        default: ;
      endcase
      n_exec++;
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_disp = 0; m_z = 1'b0; m_c = 1'b0;
  endtask

  task automatic prog_word(input int addr, input logic [7:0] data);
    @(negedge CLK);
    run_or_prog        = 1'b0;
    prog_write         = 1'b1;
    programmer_address = 4'(addr);
    programmer_data    = data;
    @(posedge CLK);
    m_ram[addr] = data;
    @(negedge CLK);
    prog_write = 1'b0;
  endtask

  task automatic load_program();
    for (int i = 0; i < DEPTH; i++) prog_word(i, prog_img[i]);
  endtask

  task automatic clear_img();
    for (int i = 0; i < DEPTH; i++) prog_img[i] = 8'h00;
  endtask

  task automatic hw_reset(input string tag);
    @(negedge CLK);
    CLR_bar     = 1'b0;
    run_or_prog = 1'b0;
    prog_write  = 1'b0;
    #2;
    check_output({tag, "_rst_display"}, display, 0);
    check_output({tag, "_rst_valid"}, display_valid, 0);
    check_output({tag, "_rst_hlt_bar"}, HLT_bar, 1);
    check_output({tag, "_rst_tstate"}, t_state, 0);
    model_reset();
    @(negedge CLK);
    CLR_bar = 1'b1;
  endtask

  // Runs from address 0 until the model's halt edge (or an instruction budget),
  // then returns to program mode.
  task automatic apply_stimulus(input int max_instr, input string tag);
    int n_exec;
    bit halted;
    int edges;
    run_model(max_instr, n_exec, halted);
    edges = halted ? 6 * n_exec + 4 : 6 * max_instr;
    @(negedge CLK);
    CLR_bar            = 1'b1;
    run_or_prog        = 1'b1;
    prog_write         = 1'b1;
    programmer_address = 4'($urandom);
    programmer_data    = 8'($urandom);
    repeat (edges - 1) @(posedge CLK);
    #1 check_output({tag, "_hlt_bar_before_end"}, HLT_bar, 1);
    @(posedge CLK);
    #1;
    if (halted) begin
      check_output({tag, "_halt_edge"}, HLT_bar, 0);
      repeat (3) @(posedge CLK);
      #1;
      check_output({tag, "_halt_held"}, HLT_bar, 0);
      check_output({tag, "_halt_tstate"}, t_state, 3);
    end else begin
      check_output({tag, "_budget_hlt_bar"}, HLT_bar, 1);
      check_output({tag, "_budget_tstate"}, t_state, 0);
    end
    check_output({tag, "_display"}, display, m_disp);
    @(negedge CLK);
    check_output({tag, "_pending_pulses"}, exp_q.size(), 0);
    exp_q.delete();
    run_or_prog = 1'b0;
    prog_write  = 1'b0;
    @(posedge CLK);
    #1;
    check_output({tag, "_prog_tstate"}, t_state, 0);
    check_output({tag, "_prog_hlt_bar"}, HLT_bar, 1);
  endtask

  initial begin
    CLR_bar            = 1'b0;
    run_or_prog        = 1'b0;
    prog_write         = 1'b0;
    programmer_address = '0;
    programmer_data    = '0;
    for (int i = 0; i < DEPTH; i++) m_ram[i] = 8'h00;
    model_reset();
    hw_reset("init");

    // LDA/ADD/SUB/OUT/HLT: 0x10+0x14-0x18, halt on the 28th edge.
    clear_img();
    prog_img[0] = 8'h09; prog_img[1] = 8'h1A; prog_img[2] = 8'h2B;
    prog_img[3] = 8'hE0; prog_img[4] = 8'hF0;
    prog_img[9] = 8'h10; prog_img[10] = 8'h14; prog_img[11] = 8'h18;
    load_program();
    apply_stimulus(50, "basic");

    // Async reset during T5 of ADD, then rerun from address 0.
    check_output("display_retained", display, 8'h0C);
    @(negedge CLK);
    run_or_prog = 1'b1;
    repeat (10) @(posedge CLK);
    #1 check_output("add_t5_reached", t_state, 4);
    #2 CLR_bar = 1'b0;
    #1;
    check_output("midrst_display", display, 0);
    check_output("midrst_valid", display_valid, 0);
    check_output("midrst_hlt_bar", HLT_bar, 1);
    check_output("midrst_tstate", t_state, 0);
    model_reset();
    apply_stimulus(50, "after_reset");

    // 0xFF + 0x01 wraps to zero with carry; JZ and JC both taken.
    clear_img();
    prog_img[0] = 8'h0D; prog_img[1] = 8'h1E; prog_img[2] = 8'h66;
    prog_img[3] = 8'h47; prog_img[4] = 8'hE0; prog_img[5] = 8'hF0;
    prog_img[6] = 8'hE0; prog_img[7] = 8'h79; prog_img[8] = 8'hF0;
    prog_img[9] = 8'h41; prog_img[10] = 8'hE0; prog_img[11] = 8'hF0;
    prog_img[13] = 8'hFF; prog_img[14] = 8'h01;
    load_program();
    apply_stimulus(50, "wrap_jz");

    // Countdown loop from 3.
    clear_img();
    prog_img[0] = 8'h43; prog_img[1] = 8'h2F; prog_img[2] = 8'hE0;
    prog_img[3] = 8'h65; prog_img[4] = 8'h51; prog_img[5] = 8'hF0;
    prog_img[15] = 8'h01;
    load_program();
    apply_stimulus(50, "countdown");

    // STA then LDA back, then reprogram only the code and read 0xD again.
    clear_img();
    prog_img[0] = 8'h0C; prog_img[1] = 8'h3D; prog_img[2] = 8'h40;
    prog_img[3] = 8'h0D; prog_img[4] = 8'hE0; prog_img[5] = 8'hF0;
    prog_img[12] = 8'h5A;
    load_program();
    apply_stimulus(50, "sta");
    prog_word(0, 8'h40);
    prog_word(1, 8'h0D);
    prog_word(2, 8'hE0);
    prog_word(3, 8'hF0);
    apply_stimulus(50, "sta_readback");

    // JMP 3 with A=0: a NOP unless jumps are built in.
    hw_reset("jmp");
    clear_img();
    prog_img[0] = 8'h53; prog_img[1] = 8'hE0; prog_img[2] = 8'hF0;
    prog_img[3] = 8'hF0;
    load_program();
    apply_stimulus(50, "jmp_nop");

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++) prog_img[i] = 8'($urandom);
      load_program();
      apply_stimulus(40, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
